// File: rtl/vga_pkg.sv
// Shared timing constants, state encoding and pixel format for the VGA line scheduler.
package vga_pkg;

  localparam int H_PIXELS    = 640;
  localparam int V_LINES     = 520;
  localparam int V_ACT_FIRST = 30;
  localparam int V_ACT_LAST  = 509;

  localparam int LINE_W = 10;
  localparam int X_W    = 10;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int PIX_W = R_W + G_W + B_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/vga_fill_ctr.sv
// Pixel counter and one-stage write pipeline into the fill bank of the line RAM.
module vga_fill_ctr
  import vga_pkg::*;
#(
  parameter int H_PIXELS = vga_pkg::H_PIXELS
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             beat,
  input  logic             clear,
  input  logic             bank,
  input  logic [PIX_W-1:0] din,
  output logic [X_W-1:0]   x,
  output logic             last_beat,
  output logic             ram_we,
  output logic [X_W:0]     ram_waddr,
  output logic [PIX_W-1:0] ram_wdata
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_PIXELS - 1);

  assign last_beat = beat && (x == X_LAST);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      x         <= '0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= beat;
      if (beat) begin
        ram_waddr <= {bank, x};
        ram_wdata <= din;
      end
      if (clear)
        x <= '0;
      else if (beat)
        x <= x + 1'b1;
    end
  end

endmodule

// File: rtl/vga_line_sched.sv
// Ping-pong line-fill scheduler: fetches line n+1 into the fill bank while line n is scanned.
module vga_line_sched
  import vga_pkg::*;
#(
  parameter int H_PIXELS    = vga_pkg::H_PIXELS,
  parameter int V_LINES     = vga_pkg::V_LINES,
  parameter int V_ACT_FIRST = vga_pkg::V_ACT_FIRST,
  parameter int V_ACT_LAST  = vga_pkg::V_ACT_LAST
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              en,
  input  logic              pulse_line,
  input  logic [LINE_W-1:0] line_num,
  output logic              fill_req,
  output logic [LINE_W-1:0] fill_line,
  output logic              fill_abort,
  input  logic              src_valid,
  input  logic [PIX_W-1:0]  src_data,
  output logic              src_ready,
  output logic              ram_we,
  output logic [X_W:0]      ram_waddr,
  output logic [PIX_W-1:0]  ram_wdata,
  output logic              disp_bank,
  output logic              busy,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_LINES - 1);
  localparam logic [LINE_W-1:0] ACT_FIRST = LINE_W'(V_ACT_FIRST);
  localparam logic [LINE_W-1:0] ACT_LAST  = LINE_W'(V_ACT_LAST);

  sched_state_t state, state_nxt;

  logic [LINE_W-1:0] nxt;
  logic              nxt_act;
  logic              start;
  logic [X_W-1:0]    x;
  logic              last_beat;
  logic              beat;
  logic              clear;
  logic              swap;
  logic              set_ur;
  logic              abort_nxt;
  logic              load_line;
  logic              fill_bank;

  // Out-of-range line numbers are treated as the last line, so they wrap to 0.
  assign nxt       = (line_num >= LAST_LINE) ? '0 : line_num + 1'b1;
  assign nxt_act   = (nxt >= ACT_FIRST) && (nxt <= ACT_LAST);
  assign start     = pulse_line && en && nxt_act;
  assign fill_bank = ~disp_bank;
  assign src_ready = (state == ST_FILL);
  assign beat      = src_valid && src_ready;
  assign fill_req  = (state == ST_REQ);
  assign busy      = (state == ST_REQ) || (state == ST_FILL);

  vga_fill_ctr #(.H_PIXELS(H_PIXELS)) u_fill_ctr (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .beat      (beat),
    .clear     (clear),
    .bank      (fill_bank),
    .din       (src_data),
    .x         (x),
    .last_beat (last_beat),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata)
  );

  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    set_ur    = 1'b0;
    abort_nxt = 1'b0;
    load_line = 1'b0;
    clear     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_REQ;
          load_line = 1'b1;
        end
      end
      ST_REQ, ST_FILL: begin
        if (!en) begin
          abort_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end else if (pulse_line) begin
          // A final beat coinciding with the line pulse still counts as a completed fill.
          if (last_beat) begin
            swap = 1'b1;
          end else begin
            set_ur    = 1'b1;
            abort_nxt = 1'b1;
          end
          load_line = start;
          state_nxt = start ? ST_REQ : ST_IDLE;
        end else if (state == ST_REQ) begin
          clear     = 1'b1;
          state_nxt = ST_FILL;
        end else if (last_beat) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (pulse_line) begin
          swap      = 1'b1;
          load_line = start;
          state_nxt = start ? ST_REQ : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      fill_line  <= '0;
      disp_bank  <= 1'b0;
      fill_abort <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      fill_abort <= abort_nxt;
      if (load_line)
        fill_line <= nxt;
      if (swap)
        disp_bank <= ~disp_bank;
      if (set_ur)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_line_sched.sv
// Scoreboard bench for vga_line_sched: expected RAM writes and fill requests are queued by stimulus.
module tb_vga_line_sched;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        pulse_line = 1'b0;
  logic [9:0]  line_num = '0;
  logic        fill_req;
  logic [9:0]  fill_line;
  logic        fill_abort;
  logic        src_valid = 1'b0;
  logic [15:0] src_data = '0;
  logic        src_ready;
  logic        ram_we;
  logic [10:0] ram_waddr;
  logic [15:0] ram_wdata;
  logic        disp_bank;
  logic        busy;
  logic        underrun;
  logic        underrun_clr = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int seed   = 1;
  logic exp_disp = 1'b0;

  logic [26:0] wq[$];
  logic [9:0]  fq[$];

  vga_line_sched dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .en           (en),
    .pulse_line   (pulse_line),
    .line_num     (line_num),
    .fill_req     (fill_req),
    .fill_line    (fill_line),
    .fill_abort   (fill_abort),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .disp_bank    (disp_bank),
    .busy         (busy),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk_sys = ~clk_sys;

  // Monitor: every RAM write and every fill request is matched against the queued expectation.
  always @(negedge clk_sys) begin
    if (!rst && ram_we) begin
      n_chk++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL ram_write: got addr=%h data=%h, required none", ram_waddr, ram_wdata);
      end else begin
        logic [26:0] e;
        e = wq.pop_front();
        if ({ram_waddr, ram_wdata} !== e) begin
          n_fail++;
          $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                   ram_waddr, ram_wdata, e[26:16], e[15:0]);
        end
      end
    end
    if (!rst && fill_req) begin
      n_chk++;
      if (fq.size() == 0) begin
        n_fail++;
        $display("FAIL fill_req: got line %0d, required no request", fill_line);
      end else begin
        logic [9:0] l;
        l = fq.pop_front();
        if (fill_line !== l) begin
          n_fail++;
          $display("FAIL fill_line: got %0d, required %0d", fill_line, l);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse(input logic [9:0] ln);
    pulse_line = 1'b1;
    line_num   = ln;
    tick();
    pulse_line = 1'b0;
  endtask

  // Called one cycle after the fill request; the first tick moves REQ to FILL.
  task automatic do_fill(input int n, input bit gaps, input bit pulse_last, input logic [9:0] ln);
    logic [15:0] d;
    tick();
    for (int i = 0; i < n; i++) begin
      if (gaps && (((i * 7 + 3) % 4) < 2)) begin
        src_valid = 1'b0;
        tick();
      end
      d = 16'(seed * 1031 + i * 7);
      src_valid = 1'b1;
      src_data  = d;
      if (i == 0) chk("src_ready", 32'(src_ready), 32'd1);
      wq.push_back({~exp_disp, 10'(i), d});
      if (pulse_last && i == n - 1) begin
        pulse_line = 1'b1;
        line_num   = ln;
      end
      tick();
      pulse_line = 1'b0;
    end
    src_valid = 1'b0;
    seed++;
  endtask

  initial begin
    tick();
    tick();
    chk("reset_outputs",
        32'({fill_req, fill_line, fill_abort, src_ready, ram_we, ram_waddr, disp_bank, busy, underrun}),
        32'd0);
    chk("reset_wdata", 32'(ram_wdata), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // First active line fill into bank 1.
    fq.push_back(10'd30);
    pulse(10'd29);
    chk("first_req", 32'(fill_req), 32'd1);
    chk("first_busy", 32'(busy), 32'd1);
    do_fill(640, 1'b0, 1'b0, 10'd0);
    tick();
    chk("done_src_ready", 32'(src_ready), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    fq.push_back(10'd31);
    exp_disp = ~exp_disp;
    pulse(10'd30);
    chk("swap_disp", 32'(disp_bank), 32'(exp_disp));

    // Source stalls after 300 beats; the line pulse forces an underrun and restart.
    do_fill(300, 1'b0, 1'b0, 10'd0);
    tick();
    fq.push_back(10'd32);
    pulse(10'd31);
    chk("ur_flag", 32'(underrun), 32'd1);
    chk("ur_abort", 32'(fill_abort), 32'd1);
    chk("ur_disp", 32'(disp_bank), 32'(exp_disp));
    chk("ur_req", 32'(fill_req), 32'd1);
    do_fill(640, 1'b0, 1'b0, 10'd0);
    chk("ur_abort_once", 32'(fill_abort), 32'd0);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("ur_clear", 32'(underrun), 32'd0);

    // Final beat coincides with the line pulse.
    fq.push_back(10'd33);
    exp_disp = ~exp_disp;
    pulse(10'd32);
    fq.push_back(10'd34);
    do_fill(640, 1'b0, 1'b1, 10'd33);
    exp_disp = ~exp_disp;
    chk("coincide_disp", 32'(disp_bank), 32'(exp_disp));
    chk("coincide_ur", 32'(underrun), 32'd0);
    chk("coincide_req", 32'(fill_req), 32'd1);

    // End of active region and frame wrap.
    do_fill(640, 1'b0, 1'b0, 10'd0);
    exp_disp = ~exp_disp;
    pulse(10'd509);
    chk("l509_req", 32'(fill_req), 32'd0);
    chk("l509_busy", 32'(busy), 32'd0);
    chk("l509_disp", 32'(disp_bank), 32'(exp_disp));
    pulse(10'd519);
    chk("l519_busy", 32'(busy), 32'd0);
    chk("l519_disp", 32'(disp_bank), 32'(exp_disp));
    pulse(10'd600);
    chk("l600_busy", 32'(busy), 32'd0);
    pulse(10'd28);
    chk("l28_busy", 32'(busy), 32'd0);

    // Frame segment with source gaps.
    for (int ln = 29; ln <= 44; ln++) begin
      fq.push_back(10'(ln + 1));
      if (ln != 29) exp_disp = ~exp_disp;
      pulse(10'(ln));
      chk("frame_disp", 32'(disp_bank), 32'(exp_disp));
      chk("frame_req", 32'(fill_req), 32'd1);
      do_fill(640, 1'b1, 1'b0, 10'd0);
    end
    chk("frame_ur", 32'(underrun), 32'd0);

    // Disable while a request is pending.
    fq.push_back(10'd46);
    exp_disp = ~exp_disp;
    pulse(10'd45);
    en = 1'b0;
    tick();
    chk("dis_abort", 32'(fill_abort), 32'd1);
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_disp", 32'(disp_bank), 32'(exp_disp));
    en = 1'b1;
    tick();

    // Underrun set and clear in the same cycle: set wins.
    fq.push_back(10'd101);
    pulse(10'd100);
    do_fill(50, 1'b0, 1'b0, 10'd0);
    underrun_clr = 1'b1;
    fq.push_back(10'd102);
    pulse(10'd101);
    underrun_clr = 1'b0;
    chk("setclr_ur", 32'(underrun), 32'd1);
    chk("setclr_abort", 32'(fill_abort), 32'd1);

    // Reset in the middle of a fill.
    do_fill(100, 1'b0, 1'b0, 10'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_outputs",
        32'({fill_req, fill_line, fill_abort, src_ready, ram_we, ram_waddr, disp_bank, busy, underrun}),
        32'd0);
    chk("midrst_wdata", 32'(ram_wdata), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_idle", 32'(busy), 32'd0);

    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("fq_empty", 32'(fq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
